// File: rtl/ysyx_23060201_ifu_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encoding, the NOP
// substituted for faulted fetches, and the default boot address.
package ysyx_23060201_ifu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } ifu_state_t;

  localparam logic [31:0] NOP              = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

  function automatic logic misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/ysyx_23060201_ifu_buf.sv
// Holding register for the fetched instruction presented to the decoder.
// Load wins over clear so a faulting redirect can replace a held entry in place.
module ysyx_23060201_ifu_buf (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] d_data,
  input  logic [31:0] d_pc,
  input  logic        d_fault,
  output logic [31:0] q_data,
  output logic [31:0] q_pc,
  output logic        q_fault
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_data  <= 32'd0;
      q_pc    <= 32'd0;
      q_fault <= 1'b0;
    end else if (load) begin
      q_data  <= d_data;
      q_pc    <= d_pc;
      q_fault <= d_fault;
    end else if (clear) begin
      q_data  <= 32'd0;
      q_pc    <= 32'd0;
      q_fault <= 1'b0;
    end
  end

endmodule

// File: rtl/ysyx_23060201_ifu.sv
// Instruction fetch unit: one outstanding memory read at a time, a single
// holding slot toward the decoder, and redirects that discard in-flight work.
module ysyx_23060201_ifu
  import ysyx_23060201_ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  input  logic        mem_rsp_err,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_fault
);

  ifu_state_t  state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic        stale, stale_nxt;
  logic        req_hs, inst_hs, redir_mis;
  logic        buf_load, buf_clear, load_fault;
  logic [31:0] load_data, load_pc;

  // Handshakes: a transfer happens on a rising edge where valid & ready are
  // both 1; valid never depends on ready, and a response is taken only in WAIT.
  // While stale, a response for an abandoned request is still owed, so no new
  // request is issued until it has been seen and dropped.
  assign mem_req_valid = (state == ST_REQ) && !stale;
  assign inst_valid    = (state == ST_HOLD);
  assign req_hs        = mem_req_valid & mem_req_ready;
  assign inst_hs       = inst_valid & inst_ready;
  assign redir_mis     = misaligned(redirect_pc);
  assign mem_req_addr  = pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      pc    <= RESET_PC;
      stale <= 1'b0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      stale <= stale_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    stale_nxt  = stale;
    buf_load   = 1'b0;
    buf_clear  = 1'b0;
    load_data  = NOP;
    load_pc    = pc;
    load_fault = 1'b0;

    // Outside WAIT a response can only belong to an abandoned request.
    if ((state == ST_REQ || state == ST_HOLD) && mem_rsp_valid) stale_nxt = 1'b0;

    case (state)
      ST_IDLE: state_nxt = ST_REQ;

      ST_REQ: begin
        if (redirect_valid) begin
          pc_nxt = redirect_pc;
          if (redir_mis) begin
            buf_load   = 1'b1;
            load_pc    = redirect_pc;
            load_fault = 1'b1;
            state_nxt  = ST_HOLD;
            if (req_hs) stale_nxt = 1'b1;
          end else if (req_hs) begin
            stale_nxt = 1'b1;
            state_nxt = ST_WAIT;
          end
        end else if (req_hs) begin
          state_nxt = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (redirect_valid) begin
          pc_nxt = redirect_pc;
          if (redir_mis) begin
            buf_load   = 1'b1;
            load_pc    = redirect_pc;
            load_fault = 1'b1;
            stale_nxt  = !mem_rsp_valid;
            state_nxt  = ST_HOLD;
          end else if (mem_rsp_valid) begin
            stale_nxt = 1'b0;
            state_nxt = ST_REQ;
          end else begin
            stale_nxt = 1'b1;
          end
        end else if (mem_rsp_valid) begin
          if (stale) begin
            stale_nxt = 1'b0;
            state_nxt = ST_REQ;
          end else begin
            buf_load   = 1'b1;
            load_data  = mem_rsp_err ? NOP : mem_rsp_data;
            load_pc    = pc;
            load_fault = mem_rsp_err;
            state_nxt  = ST_HOLD;
          end
        end
      end

      ST_HOLD: begin
        if (redirect_valid) begin
          pc_nxt = redirect_pc;
          if (redir_mis) begin
            buf_load   = 1'b1;
            load_pc    = redirect_pc;
            load_fault = 1'b1;
          end else begin
            buf_clear = 1'b1;
            state_nxt = ST_REQ;
          end
        end else if (inst_hs) begin
          pc_nxt    = pc + 32'd4;
          buf_clear = 1'b1;
          state_nxt = ST_REQ;
        end
      end

      default: state_nxt = ST_IDLE;
    endcase
  end

  ysyx_23060201_ifu_buf u_buf (
    .clk     (clk),
    .rst     (rst),
    .load    (buf_load),
    .clear   (buf_clear),
    .d_data  (load_data),
    .d_pc    (load_pc),
    .d_fault (load_fault),
    .q_data  (inst),
    .q_pc    (inst_pc),
    .q_fault (inst_fault)
  );

endmodule

// File: tb/tb_ysyx_23060201_ifu.sv
// Bench for the fetch unit: directed scenarios followed by random traffic,
// scored against an instruction-stream model (next PC = last PC + 4 unless redirected).
module tb_ysyx_23060201_ifu;

  localparam logic [31:0] RPC      = 32'h8000_0000;
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_data = 32'd0;
  logic        mem_rsp_err = 1'b0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_fault;

  ysyx_23060201_ifu #(.RESET_PC(RPC)) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rsp_data   (mem_rsp_data),
    .mem_rsp_err    (mem_rsp_err),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_fault     (inst_fault)
  );

  // clock/reset block
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  // scoreboard state
  logic [31:0] exp_q[$];
  logic [31:0] pend_addr[$];
  int unsigned pend_cnt[$];
  int          n_checks = 0;
  int          n_pass = 0;
  int          n_deliv = 0;
  int          idle_cyc = 0;
  int unsigned lat_min = 0;
  int unsigned lat_max = 0;
  logic        prev_iv = 1'b0;
  logic        prev_leave = 1'b0;
  logic [64:0] prev_out = '0;
  logic [64:0] held;
  logic        rv_r;
  logic [31:0] rpc_r;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == RPC) return 32'h0010_0093;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic mem_err(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a == 32'h8000_0008) || (a[7:2] == 6'h2A);
  endfunction

  task automatic check(input string tag, input logic [64:0] got, input logic [64:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    redirect_valid = 1'b0; redirect_pc = 32'd0; mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0; mem_rsp_data = 32'd0; mem_rsp_err = 1'b0; inst_ready = 1'b0;
    pend_addr.delete(); pend_cnt.delete();
    #1;
    check("rst_mem_req_valid", mem_req_valid, 0);
    check("rst_inst_valid", inst_valid, 0);
    check("rst_inst_fault", inst_fault, 0);
    check("rst_inst", inst, 0);
    check("rst_inst_pc", inst_pc, 0);
    check("rst_mem_req_addr", mem_req_addr, RPC);
    repeat (2) @(posedge clk);
    #1;
    check("rst_held_inst_valid", inst_valid, 0);
    rst = 1'b0;
    exp_q.delete(); exp_q.push_back(RPC);
    prev_iv = 1'b0; prev_leave = 1'b0; idle_cyc = 0;
  endtask

  // driver: one clock cycle of inputs, memory model and scoring
  task automatic cycle(input logic rv, input logic [31:0] rpc, input logic qr, input logic ir);
    logic [31:0] a;
    logic [31:0] e;
    redirect_valid = rv; redirect_pc = rpc; mem_req_ready = qr; inst_ready = ir;
    mem_rsp_valid = 1'b0; mem_rsp_data = 32'd0; mem_rsp_err = 1'b0;
    if (pend_cnt.size() > 0 && pend_cnt[0] == 0) begin
      a = pend_addr.pop_front();
      void'(pend_cnt.pop_front());
      mem_rsp_valid = 1'b1;
      mem_rsp_err   = mem_err(a);
      mem_rsp_data  = mem_rsp_err ? 32'hDEAD_BEEF : mem_word(a);
    end
    foreach (pend_cnt[i]) if (pend_cnt[i] > 0) pend_cnt[i] = pend_cnt[i] - 1;

    check("req_inst_exclusive", inst_valid & mem_req_valid, 0);
    if (prev_iv && !prev_leave) begin
      check("hold_valid", inst_valid, 1);
      check("hold_stable", {inst_fault, inst_pc, inst}, prev_out);
    end
    if (inst_valid && ir) begin
      e = exp_q[0];
      check("inst_pc", inst_pc, e);
      check("inst_fault", inst_fault, mem_err(e));
      check("inst_word", inst, mem_err(e) ? NOP_WORD : mem_word(e));
      n_deliv++;
      idle_cyc = 0;
    end else begin
      idle_cyc++;
    end

    if (rv) begin
      exp_q.delete(); exp_q.push_back(rpc);
    end else if (inst_valid && ir) begin
      e = exp_q.pop_front();
      exp_q.push_back(e + 32'd4);
    end
    if (mem_req_valid && qr) begin
      pend_addr.push_back(mem_req_addr);
      pend_cnt.push_back($urandom_range(lat_min, lat_max));
    end
    prev_iv    = inst_valid;
    prev_leave = rv || (inst_valid && ir);
    prev_out   = {inst_fault, inst_pc, inst};
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2;
    reset_dut();

    // zero-latency boot fetch
    check("idle_no_req", mem_req_valid, 0);
    cycle(1'b0, 32'd0, 1'b1, 1'b0);
    check("req_after_idle", mem_req_valid, 1);
    check("req_addr_reset", mem_req_addr, RPC);
    cycle(1'b0, 32'd0, 1'b1, 1'b0);
    check("wait_no_inst", inst_valid, 0);
    cycle(1'b0, 32'd0, 1'b0, 1'b0);
    check("inst_valid_cycle3", inst_valid, 1);
    check("first_inst", inst, 32'h0010_0093);
    check("first_pc", inst_pc, RPC);
    cycle(1'b0, 32'd0, 1'b0, 1'b1);
    check("next_req_valid", mem_req_valid, 1);
    check("next_req_addr", mem_req_addr, RPC + 32'd4);

    // decoder stalls for five cycles
    cycle(1'b0, 32'd0, 1'b1, 1'b0);
    cycle(1'b0, 32'd0, 1'b0, 1'b0);
    held = {inst_fault, inst_pc, inst};
    check("stall_held_pc", inst_pc, RPC + 32'd4);
    repeat (5) begin
      cycle(1'b0, 32'd0, 1'b1, 1'b0);
      check("stall_no_req", mem_req_valid, 0);
      check("stall_outputs", {inst_fault, inst_pc, inst}, held);
    end
    cycle(1'b0, 32'd0, 1'b1, 1'b1);

    // access fault at 0x8000_0008
    cycle(1'b0, 32'd0, 1'b1, 1'b0);
    cycle(1'b0, 32'd0, 1'b0, 1'b0);
    check("err_fault", inst_fault, 1);
    check("err_inst_nop", inst, NOP_WORD);
    check("err_pc", inst_pc, 32'h8000_0008);
    cycle(1'b0, 32'd0, 1'b0, 1'b1);
    check("after_err_addr", mem_req_addr, 32'h8000_000C);

    // redirect coinciding with a response in WAIT
    cycle(1'b0, 32'd0, 1'b1, 1'b0);
    cycle(1'b1, 32'h8000_0100, 1'b0, 1'b0);
    check("redir_req_valid", mem_req_valid, 1);
    check("redir_req_addr", mem_req_addr, 32'h8000_0100);
    check("redir_dropped", inst_valid, 0);
    cycle(1'b0, 32'd0, 1'b1, 1'b0);
    cycle(1'b0, 32'd0, 1'b0, 1'b0);
    check("redir_inst_pc", inst_pc, 32'h8000_0100);
    cycle(1'b0, 32'd0, 1'b0, 1'b1);

    // misaligned redirect
    cycle(1'b1, 32'h8000_0102, 1'b0, 1'b0);
    check("mis_inst_valid", inst_valid, 1);
    check("mis_fault", inst_fault, 1);
    check("mis_inst_nop", inst, NOP_WORD);
    check("mis_pc", inst_pc, 32'h8000_0102);
    check("mis_no_req", mem_req_valid, 0);
    cycle(1'b1, RPC, 1'b0, 1'b1);
    check("mis_back_addr", mem_req_addr, RPC);

    // reset in the middle of WAIT, then a late response during IDLE
    lat_min = 3; lat_max = 3;
    cycle(1'b0, 32'd0, 1'b1, 1'b0);
    cycle(1'b0, 32'd0, 1'b0, 1'b0);
    check("midwait_no_inst", inst_valid, 0);
    #2;
    reset_dut();
    pend_addr.push_back(32'h8000_0F00);
    pend_cnt.push_back(0);
    cycle(1'b0, 32'd0, 1'b1, 1'b0);
    check("restart_req_valid", mem_req_valid, 1);
    check("restart_req_addr", mem_req_addr, RPC);
    check("late_rsp_ignored", inst_valid, 0);
    lat_min = 0; lat_max = 0;
    cycle(1'b0, 32'd0, 1'b1, 1'b0);
    cycle(1'b0, 32'd0, 1'b0, 1'b0);
    check("restart_inst", inst, 32'h0010_0093);
    cycle(1'b0, 32'd0, 1'b0, 1'b1);

    // random traffic
    lat_min = 0; lat_max = 3;
    for (int k = 0; k < 4000; k++) begin
      rv_r  = ($urandom_range(0, 15) == 0);
      rpc_r = RPC + ($urandom_range(0, 63) << 2);
      if ($urandom_range(0, 3) == 0) rpc_r[1:0] = 2'($urandom_range(1, 3));
      cycle(rv_r, rpc_r, 1'($urandom_range(0, 1)), ($urandom_range(0, 2) != 0));
      if (idle_cyc > 200) begin
        check("watchdog_stall", idle_cyc, 0);
        break;
      end
    end
    check("random_deliveries", n_deliv > 100, 1);

    // final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ysyx_23060201_ifu.md
YSYX_23060201_IFU -- requirements
Module: ysyx_23060201_ifu

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h8000_0000: first fetch address after reset.
REQ-002 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  in  1  reset; asynchronous and active-high.
REQ-004 SHALL have port redirect_valid  in  1  execute stage requests a fetch redirect this cycle.
REQ-005 SHALL have port redirect_pc  in  32  redirect target; valid only with redirect_valid.
REQ-006 SHALL have port mem_req_valid  out  1  fetch request to instruction memory.
REQ-007 SHALL have port mem_req_ready  in  1  memory accepts the request; handshake = valid & ready.
REQ-008 SHALL have port mem_req_addr  out  32  fetch address; equals the PC register.
REQ-009 SHALL have port mem_rsp_valid  in  1  read data returned; accepted unconditionally in WAIT.
REQ-010 SHALL have port mem_rsp_data  in  32  instruction word.
REQ-011 SHALL have port mem_rsp_err  in  1  access fault qualifying mem_rsp_valid.
REQ-012 SHALL have port inst_valid  out  1  instruction available to the decoder.
REQ-013 SHALL have port inst_ready  in  1  decoder consumes; handshake = inst_valid & inst_ready.
REQ-014 SHALL have port inst  out  32  instruction word to the decoder.
REQ-015 SHALL have port inst_pc  out  32  PC of inst.
REQ-016 SHALL have port inst_fault  out  1  inst is a faulted fetch; inst is then forced to the NOP 32'h0000_0013.

Function
REQ-017 SHALL implement FSM states IDLE, REQ, WAIT, HOLD; at most one outstanding memory request.
REQ-018 IDLE SHALL last exactly one cycle after reset release, then go to REQ.
REQ-019 In REQ, mem_req_valid SHALL be 1; on handshake go to WAIT; mem_req_addr MAY change before handshake (bus allows it).
REQ-020 In WAIT, on mem_rsp_valid SHALL latch data/err into the holding register and go to HOLD; minimum fetch latency REQ->inst_valid is 2 cycles.
REQ-021 In HOLD, inst_valid SHALL be 1 with inst, inst_pc, inst_fault stable until handshake; on handshake PC <= PC+4 (wrapping mod 2^32), go to REQ.
REQ-022 redirect_valid SHALL have priority over every other event, in any state except IDLE.
REQ-023 Redirect in REQ: PC <= redirect_pc; if the request handshakes in the same cycle, set stale and go to WAIT, else stay in REQ.
REQ-024 Redirect in WAIT: PC <= redirect_pc, stale <= 1; the next response, including one arriving in the same cycle, SHALL be dropped, then go to REQ with stale cleared.
REQ-025 Redirect in HOLD: held instruction discarded; if inst_ready is also 1, the instruction counts as consumed; PC <= redirect_pc (not PC+4); go to REQ.
REQ-026 Redirect with redirect_pc[1:0] != 0 SHALL issue no memory request; go directly to HOLD with inst_fault=1, inst=NOP, inst_pc=redirect_pc.
REQ-027 mem_rsp_err=1 SHALL produce inst_fault=1, inst=NOP, inst_pc=fetch PC.
REQ-028 inst_valid and mem_req_valid SHALL never both be 1 in the same cycle.

Reset
REQ-029 On rst=1, outputs SHALL be 0 immediately (asynchronously): mem_req_valid, inst_valid, inst_fault, inst, inst_pc.
REQ-030 On rst=1, state SHALL be IDLE, PC SHALL be RESET_PC, stale SHALL be 0, and mem_req_addr SHALL read RESET_PC.
REQ-031 Reset during WAIT SHALL abandon the outstanding request; a late response arriving in IDLE SHALL be ignored.

Structure
REQ-032 The shared defines file SHALL hold the FSM state encodings, the NOP constant and the default RESET_PC.
REQ-033 The holding register SHALL be one sub-module, ysyx_23060201_ifu_buf, storing data/pc/fault with load and clear inputs.

Verification
REQ-034 Reset release with zero-latency memory returning 32'h0010_0093 -> inst_valid in cycle 3, inst_pc=32'h8000_0000; then next request at 32'h8000_0004.
REQ-035 inst_ready held 0 for 5 cycles in HOLD -> inst, inst_pc, inst_fault stable, and no memory request issued.
REQ-036 Redirect to 32'h8000_0100 in the same cycle as mem_rsp_valid in WAIT -> response dropped; next mem_req_addr=32'h8000_0100.
REQ-037 Redirect to 32'h8000_0102 -> no request; inst_valid with inst_fault=1, inst=32'h0000_0013, inst_pc=32'h8000_0102.
REQ-038 mem_rsp_err=1 at PC 32'h8000_0008 -> inst_fault=1, inst=NOP; after consume, next fetch at 32'h8000_000C.
REQ-039 rst asserted mid-WAIT, then a response arrives -> outputs 0 immediately; the response is ignored; fetch restarts at 32'h8000_0000.
